// File: rtl/merger_pkg.sv
// merger_pkg: shared state encoding, word geometry and tuple helpers for merger_p.
// Helpers work on words zero-extended to MAX_WORD_W so that any parameterisation
// of the merger up to that width can share them.
package merger_pkg;

    localparam int unsigned DEF_LANES      = 8;
    localparam int unsigned DEF_DATA_WIDTH = 128;
    localparam int unsigned DEF_KEY_WIDTH  = 80;
    localparam int unsigned WORD_W         = DEF_LANES * DEF_DATA_WIDTH;

    // Widest word / key the helper functions accept (32 lanes of 128-bit tuples).
    localparam int unsigned MAX_WORD_W = 4096;
    localparam int unsigned MAX_KEY_W  = 128;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        MERGE = 2'd1,
        FLUSH = 2'd2,
        TERM  = 2'd3
    } state_t;

    // A run ends with a word that is entirely zero.
    function automatic logic is_terminal(input logic [MAX_WORD_W-1:0] word);
        return (word == '0);
    endfunction

    // Key field of tuple 'lane' inside a word of data_w-bit tuples.
    function automatic logic [MAX_KEY_W-1:0] key_of(
        input logic [MAX_WORD_W-1:0] word,
        input int unsigned           lane,
        input int unsigned           data_w,
        input int unsigned           key_w
    );
        logic [MAX_WORD_W-1:0] shifted;
        logic [MAX_KEY_W-1:0]  mask;
        shifted = word >> (lane * data_w);
        mask    = '1;
        mask    = mask >> (MAX_KEY_W - key_w);
        return shifted[MAX_KEY_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/bitonic_merge_2p.sv
// bitonic_merge_2p: combinational merge of two ascending LANES-tuple vectors.
// i_a followed by lane-reversed i_b forms a bitonic sequence; log2(2*LANES)
// half-cleaner stages then sort it. o_lo gets the smallest LANES tuples.
module bitonic_merge_2p #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEY_WIDTH  = 80
) (
    input  logic [LANES*DATA_WIDTH-1:0] i_a,
    input  logic [LANES*DATA_WIDTH-1:0] i_b,
    output logic [LANES*DATA_WIDTH-1:0] o_lo,
    output logic [LANES*DATA_WIDTH-1:0] o_hi
);

    localparam int unsigned N = 2 * LANES;

    logic [DATA_WIDTH-1:0] net [N];
    logic [DATA_WIDTH-1:0] tmp;

    // Load the bitonic sequence, run the compare-exchange stages, split the result
    always_comb begin
        tmp  = '0;
        o_lo = '0;
        o_hi = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            net[i]         = i_a[i*DATA_WIDTH +: DATA_WIDTH];
            net[N - 1 - i] = i_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int unsigned d = LANES; d > 0; d = d / 2) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                // j-th pair at distance d: lower index has bit d clear
                int unsigned lo_idx;
                lo_idx = ((j & ~(d - 1)) << 1) | (j & (d - 1));
                if (net[lo_idx][KEY_WIDTH-1:0] > net[lo_idx + d][KEY_WIDTH-1:0]) begin
                    tmp              = net[lo_idx];
                    net[lo_idx]      = net[lo_idx + d];
                    net[lo_idx + d]  = tmp;
                end
            end
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            o_lo[i*DATA_WIDTH +: DATA_WIDTH] = net[i];
            o_hi[i*DATA_WIDTH +: DATA_WIDTH] = net[LANES + i];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and a combinational head.
// A read and a write in the same cycle always both take effect, so the
// occupancy is unchanged even when the FIFO is full or empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_en,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Status flags, accepted operations and next pointer values
    always_comb begin
        o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        o_empty   = (wr_ptr_q == rd_ptr_q);
        do_wr     = i_wr_en && (!o_full || i_rd_en);
        do_rd     = i_rd_en && (!o_empty || i_wr_en);
        wr_ptr_d  = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d  = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        o_rd_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written on accepted pushes
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/merger_p.sv
// merger_p: two-way streaming merger for the sort tree. Two sorted input streams
// of LANES-tuple words are merged through a LANES-tuple residue register R into
// one sorted output stream; runs end in an all-zero word and the block flushes
// and restarts at every run boundary.
// Optional build macro: MERGER_P_RUN_COUNT_EN adds the 32-bit o_run_count port
// counting terminal words delivered downstream.
module merger_p #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEY_WIDTH  = 80,
    parameter int unsigned LANES      = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [LANES*DATA_WIDTH-1:0] i_a_data,
    input  logic                        i_a_valid,
    output logic                        o_a_ready,
    input  logic [LANES*DATA_WIDTH-1:0] i_b_data,
    input  logic                        i_b_valid,
    output logic                        o_b_ready,
    output logic [LANES*DATA_WIDTH-1:0] o_data,
    output logic                        o_valid,
    input  logic                        i_ready
`ifdef MERGER_P_RUN_COUNT_EN
    ,
    output logic [31:0]                 o_run_count
`endif
);

    import merger_pkg::*;

    localparam int unsigned WORD_BITS = LANES * DATA_WIDTH;

    logic                  fifo_a_full, fifo_a_empty, fifo_b_full, fifo_b_empty;
    logic [WORD_BITS-1:0]  head_a, head_b;
    logic                  pop_a, pop_b;
    logic [MAX_WORD_W-1:0] head_a_x, head_b_x;
    logic [MAX_KEY_W-1:0]  key_a, key_b;
    logic                  a_term, b_term, both_term, both_present;
    logic                  sel_a, slot;
    logic [WORD_BITS-1:0]  sel_word, merge_lo, merge_hi;

    state_t                state_q, state_d;
    logic [WORD_BITS-1:0]  r_q, r_d;
    logic [WORD_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;

    assign o_a_ready = !i_rst && !fifo_a_full;
    assign o_b_ready = !i_rst && !fifo_b_full;
    assign o_data    = data_q;
    assign o_valid   = valid_q;

    sync_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_data (i_a_data),
        .i_wr_en   (i_a_valid && o_a_ready),
        .o_full    (fifo_a_full),
        .i_rd_en   (pop_a),
        .o_rd_data (head_a),
        .o_empty   (fifo_a_empty)
    );

    sync_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_data (i_b_data),
        .i_wr_en   (i_b_valid && o_b_ready),
        .o_full    (fifo_b_full),
        .i_rd_en   (pop_b),
        .o_rd_data (head_b),
        .o_empty   (fifo_b_empty)
    );

    bitonic_merge_2p #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH)
    ) u_merge (
        .i_a  (r_q),
        .i_b  (sel_word),
        .o_lo (merge_lo),
        .o_hi (merge_hi)
    );

    // Head classification and the select rule (ties favour A)
    always_comb begin
        head_a_x                  = '0;
        head_a_x[WORD_BITS-1:0]   = head_a;
        head_b_x                  = '0;
        head_b_x[WORD_BITS-1:0]   = head_b;
        a_term       = is_terminal(head_a_x);
        b_term       = is_terminal(head_b_x);
        both_term    = a_term && b_term;
        both_present = !fifo_a_empty && !fifo_b_empty;
        key_a        = key_of(head_a_x, 32'd0, DATA_WIDTH, KEY_WIDTH);
        key_b        = key_of(head_b_x, 32'd0, DATA_WIDTH, KEY_WIDTH);
        if (a_term) begin
            sel_a = 1'b0;
        end else if (b_term) begin
            sel_a = 1'b1;
        end else begin
            sel_a = (key_a <= key_b);
        end
        sel_word = sel_a ? head_a : head_b;
        slot     = !valid_q || i_ready;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (both_present) begin
                    state_d = both_term ? TERM : MERGE;
                end
            end
            MERGE: begin
                if (both_present && slot && both_term) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (slot) begin
                    state_d = TERM;
                end
            end
            TERM: begin
                if (slot) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Output/datapath logic: pops, residue update and output word
    always_comb begin
        pop_a   = 1'b0;
        pop_b   = 1'b0;
        r_d     = r_q;
        data_d  = data_q;
        // a free slot with nothing to emit drops valid; a stalled word is held
        valid_d = slot ? 1'b0 : valid_q;
        unique case (state_q)
            FILL: begin
                if (both_present && !both_term) begin
                    r_d   = sel_word;
                    pop_a = sel_a;
                    pop_b = !sel_a;
                end
            end
            MERGE: begin
                if (both_present && slot && !both_term) begin
                    pop_a   = sel_a;
                    pop_b   = !sel_a;
                    data_d  = merge_lo;
                    r_d     = merge_hi;
                    valid_d = 1'b1;
                end
            end
            FLUSH: begin
                if (slot) begin
                    data_d  = r_q;
                    valid_d = 1'b1;
                end
            end
            TERM: begin
                if (slot) begin
                    data_d  = '0;
                    valid_d = 1'b1;
                    pop_a   = both_present;
                    pop_b   = both_present;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef MERGER_P_RUN_COUNT_EN
    logic [31:0] run_count_q, run_count_d;

    assign o_run_count = run_count_q;

    // Count terminal words accepted downstream, wrapping at 2^32
    always_comb begin
        run_count_d = run_count_q;
        if (valid_q && i_ready && (data_q == '0)) begin
            run_count_d = run_count_q + 32'd1;
        end
    end

    // Run counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_count_q <= '0;
        end else begin
            run_count_q <= run_count_d;
        end
    end
`endif

endmodule

// File: doc/merger_p.md
Name: merger_p

Overview:
- Parametrised two-way streaming merger for the sort tree.
- Merges two sorted input streams, each carrying LANES tuples per word, into one sorted output stream of LANES tuples per word.
- Each input has its own buffer FIFO and a valid/ready handshake; the output also uses valid/ready.
- Sorted runs are delimited by an all-zero terminal word. The block flushes and restarts at each run boundary, so it cascades directly into deeper merge trees.

Parameters:
- DATA_WIDTH, 128, bits per tuple.
- KEY_WIDTH, 80, key field of a tuple, bits [KEY_WIDTH-1:0] within that tuple.
- LANES, 8, tuples per word; power of two, 1..32.
- FIFO_DEPTH, 16, words per input FIFO; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_a_data  in  LANES*DATA_WIDTH  input A word; tuple 0 in the low bits, lanes ascending by key.
- i_a_valid  in  1  A word present.
- o_a_ready  out  1  A FIFO can accept a word.
- i_b_data, i_b_valid, o_b_ready  same as A, for input B.
- o_data  out  LANES*DATA_WIDTH  merged output word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Transfers: a word transfers on any edge where valid and ready are both high. o_a_ready = !i_rst && !fifo_a_full, and likewise for B.
- Reset values: o_valid=0, o_data=0, o_a_ready=o_b_ready=0 while i_rst is high. Both FIFOs are emptied, R=0, state=FILL. Reset mid-run discards all buffered data.
- Terminal word: the whole word equals 0. Real tuples must have a nonzero key.
- Output slot free (SLOT): !o_valid || i_ready. While o_valid && !i_ready, o_data is held and no FIFO pops occur.
- Select rule: needs both FIFO heads present.
  - A terminal: choose B.
  - B terminal: choose A.
  - Otherwise compare the keys of tuple 0. A wins when key_A <= key_B (ties go to A).
- Merge: bitonic merge of register R (LANES tuples, sorted) with the selected word. The lower LANES tuples go to o_data; the upper LANES tuples go to R.
- FSM:
  - FILL: wait for both heads.
    - Both terminal: go to TERM.
    - Otherwise load R with the selected word, pop it, go to MERGE. No output.
  - MERGE: when both heads are present and SLOT:
    - Both terminal: go to FLUSH.
    - Otherwise pop the selected word, o_data <= lower half, R <= upper half, o_valid <= 1.
  - FLUSH: on SLOT, o_data <= R, o_valid <= 1, go to TERM.
  - TERM: on SLOT, o_data <= 0, o_valid <= 1, pop both terminal heads, go to FILL.
  - In any state, SLOT with nothing to emit drives o_valid <= 0.
- Latency:
  - A word accepted at edge t is a FIFO head at t+1.
  - Its merge result is registered at the first later edge where the FSM pops it.
  - Throughput is one output word per cycle in steady MERGE.
- Word counts: a run of Na+Nb input words produces Na+Nb output words plus 1 terminal.
- FIFO boundaries: a full FIFO deasserts ready the same cycle. Simultaneous enqueue and dequeue on a full or empty FIFO is legal; count is unchanged.

Optional Feature:
- MERGER_P_RUN_COUNT_EN defined: adds output port o_run_count, 32 bits.
  - Reset to 0.
  - Increments by 1 when a terminal word transfers on the output (o_valid && i_ready && o_data==0).
  - Wraps modulo 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package merger_pkg holds:
  - WORD_W = LANES*DATA_WIDTH.
  - State enum {FILL, MERGE, FLUSH, TERM}.
  - Function is_terminal(word).
  - Function key_of(word, lane).
- Sub-module bitonic_merge_2p: purely combinational merger of two sorted LANES-tuple vectors, with the second vector lane-reversed internally. Parameterised by LANES, DATA_WIDTH and KEY_WIDTH.
- Input FIFOs use the team's standard synchronous FIFO with FIFO_DEPTH.

Test Plan (LANES=4, keys listed per word):
- Basic run:
  - Stimulus: A {1,3,5,7},{9,11,13,15},term; B {2,4,6,8},{10,12,14,16},term.
  - Response: {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16},0; state back in FILL.
- Backpressure:
  - Stimulus: the basic run with i_ready low for 5 cycles after the second output.
  - Response: o_data held stable at {5,6,7,8} with o_valid=1, no pops, identical final sequence.
- Empty runs:
  - Stimulus: A and B each carry only a terminal.
  - Response: exactly one output word 0, then a second run merges correctly.
- Ties:
  - Stimulus: A {5,5,5,5},term; B {5,5,5,5},term.
  - Response: A loaded first, outputs {5,5,5,5},{5,5,5,5},0.
- Reset mid-run:
  - Stimulus: assert i_rst with both FIFOs holding 3 words.
  - Response: next cycle o_valid=0 and readies=0. After release, readies=1 and the fresh basic run produces the exact basic-run output.
- Run counter (MERGER_P_RUN_COUNT_EN):
  - Stimulus: 3 consecutive basic runs.
  - Response: o_run_count reads 1, 2, 3 after each terminal transfer.
